if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage that sits between the PC register and the decode stage. It takes the current PC and issues a request to instruction memory over a req/gnt/rvalid handshake. It captures the returned word into the IF/ID pipeline register and drives the stall input of the PC register, so the PC advances only when a fetch has been accepted. It absorbs decode back-pressure with a one-entry skid buffer and squashes in-flight fetches on a branch/jump flush.

Parameters:
NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID when it is empty or flushed

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
pc  in  32  current PC from the PC register
pc_stall  out  1  to PC register stall input; 1 = hold PC
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= pc)
imem_gnt  in  1  request accepted this cycle (sampled only while imem_req=1)
imem_rvalid  in  1  response valid; at least 1 cycle after gnt
imem_rdata  in  32  fetched instruction
id_stall  in  1  decode cannot accept; hold IF/ID
flush  in  1  branch/jump taken; squash fetched and in-flight instructions
ifid_valid  out  1  IF/ID holds a live instruction
ifid_pc  out  32  PC of the instruction in IF/ID
ifid_pc4  out  32  ifid_pc + 4
ifid_instr  out  32  instruction word in IF/ID

Behaviour:
- Reset (rst=0, async): state=REQ, buf_valid=0, ifid_valid=0, ifid_pc=0, ifid_pc4=0, ifid_instr=NOP_INSTR. Outputs during reset: imem_req=0, pc_stall=1.
- Single outstanding request. Internal regs: req_pc, buf_valid, buf_pc, buf_instr.
- States:
  - REQ: imem_req = !buf_valid && !flush; imem_addr = pc. On imem_req && imem_gnt: req_pc <= pc, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: deliver the response (see below), go to REQ.
  - DROP: imem_req=0. On imem_rvalid: discard the data, go to REQ.
- pc_stall = !(flush || (state==REQ && imem_req && imem_gnt)). The PC advances on an accepted request, or on flush so that it loads the branch target.
- Delivery, priority order on a WAIT-state rvalid:
  - Flush: data discarded.
  - Not flushing, and IF/ID can accept (!id_stall || !ifid_valid): IF/ID <= {1, req_pc, req_pc+4, imem_rdata}.
  - Otherwise: buf <= {1, req_pc, imem_rdata}.
- Buffer drain: if buf_valid && !id_stall && !flush, IF/ID <= buffer and buf_valid <= 0. A drain and a new rvalid cannot coincide, because no request is issued while buf_valid=1.
- id_stall=1 with no flush: IF/ID holds every field.
- id_stall=0 with nothing delivered: ifid_valid <= 0 and ifid_instr <= NOP_INSTR; ifid_pc and ifid_pc4 hold.
- Flush (overrides id_stall) on the next edge:
  - ifid_valid <= 0, ifid_instr <= NOP_INSTR, buf_valid <= 0.
  - In WAIT without rvalid this cycle: go to DROP.
  - In WAIT with rvalid: go to REQ.
  - In REQ: stay in REQ, no request issued this cycle.
  - In DROP: stay in DROP.
- Arithmetic: pc+4 is a 32-bit modulo add; 0xFFFF_FFFC + 4 = 0x0000_0000.
- Throughput: at most one instruction per 2 cycles (gnt cycle, then rvalid cycle at the earliest).
- X safety: no state update is predicated on X inputs. imem_gnt is ignored when imem_req=0, and imem_rvalid is ignored in REQ.

Decomposition:
- Shared definitions file: state encodings (IF_REQ, IF_WAIT, IF_DROP) and the NOP_INSTR constant (32'h0000_0000).
- One sub-module: ifid_reg, holding the IF/ID register with load/hold/clear controls and the pc4 adder. Skid buffer and FSM stay in if_stage.

Test Plan:
- Reset release, pc=0x0000_0000, gnt=1 and rvalid one cycle later, repeated. Required: ifid_pc sequence 0x0, 0x4, 0x8, new entry every 2 cycles, ifid_pc4 = ifid_pc+4, pc_stall=0 only on gnt cycles.
- gnt held 0 for 3 cycles at pc=0x10. Required: imem_req stays 1, imem_addr=0x10, pc_stall=1 throughout; fetch completes when gnt rises.
- id_stall=1 while ifid holds 0x20 and the response for 0x24 arrives. Required: buf captures 0x24, no new imem_req. Release id_stall: ifid_pc=0x24 next edge, imem_req resumes for 0x28.
- flush in WAIT one cycle before rvalid for 0x30. Required: state DROP, data for 0x30 never reaches IF/ID (ifid_valid=0, instr=NOP_INSTR), pc_stall=0 on the flush cycle, next request at target pc=0x100.
- flush and id_stall both 1 with buffer full. Required: ifid_valid=0, buf_valid=0 next edge.
- ifid_pc=0xFFFF_FFFC. Required: ifid_pc4=0x0000_0000.
- rst driven low mid-WAIT. Required: all outputs take reset values immediately, without waiting for a clock edge; a late rvalid after reset release is ignored in REQ.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage:
// FSM state encodings, the NOP word and the PC increment helper.
package if_stage_pkg;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] pc_plus4(input logic [31:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load / hold / clear controls.
// pc4 is registered at load time so it follows the reset value of 0.
module ifid_reg #(
    parameter logic [31:0] NOP = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] ld_pc,
    input  logic [31:0] ld_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr
);
    import if_stage_pkg::*;

    logic        valid_d, valid_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] pc4_d, pc4_q;
    logic [31:0] instr_d, instr_q;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        if (load) begin
            valid_d = 1'b1;
            pc_d    = ld_pc;
            pc4_d   = pc_plus4(ld_pc);
            instr_d = ld_instr;
        end else if (clear) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            pc4_q   <= 32'h0;
            instr_q <= NOP;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign pc4   = pc4_q;
    assign instr = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, one-entry skid
// buffer for decode back-pressure, squash of in-flight fetches on flush.
module if_stage #(
    parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        flush,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr
);
    import if_stage_pkg::*;

    if_state_e   state_d, state_q;
    logic [31:0] req_pc_d, req_pc_q;
    logic        buf_valid_d, buf_valid_q;
    logic [31:0] buf_pc_d, buf_pc_q;
    logic [31:0] buf_instr_d, buf_instr_q;

    logic        accept;
    logic        rsp;
    logic        can_accept;
    logic        ld;
    logic        clr;
    logic [31:0] ld_pc;
    logic [31:0] ld_instr;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IF_REQ;
            req_pc_q    <= 32'h0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    // Outputs; gated by rst so reset values appear without a clock edge
    always_comb begin
        imem_req  = rst && (state_q == IF_REQ) && !buf_valid_q && !flush;
        imem_addr = pc;
        accept    = imem_req && imem_gnt;
        pc_stall  = !(rst && (flush || accept));
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IF_REQ: begin
                if (accept) state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if (imem_rvalid) state_d = IF_REQ;
                else if (flush)  state_d = IF_DROP;
            end
            IF_DROP: begin
                if (imem_rvalid) state_d = IF_REQ;
            end
            default: state_d = IF_REQ;
        endcase
    end

    // Delivery, skid buffer and IF/ID control
    always_comb begin
        rsp         = (state_q == IF_WAIT) && imem_rvalid;
        can_accept  = !id_stall || !ifid_valid;
        req_pc_d    = accept ? pc : req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        ld          = 1'b0;
        clr         = 1'b0;
        ld_pc       = buf_pc_q;
        ld_instr    = buf_instr_q;
        if (flush) begin
            clr         = 1'b1;
            buf_valid_d = 1'b0;
        end else if (rsp) begin
            if (can_accept) begin
                ld       = 1'b1;
                ld_pc    = req_pc_q;
                ld_instr = imem_rdata;
            end else begin
                buf_valid_d = 1'b1;
                buf_pc_d    = req_pc_q;
                buf_instr_d = imem_rdata;
            end
        end else if (buf_valid_q && !id_stall) begin
            ld          = 1'b1;
            buf_valid_d = 1'b0;
        end else if (!id_stall) begin
            clr = 1'b1;
        end
    end

    ifid_reg #(
        .NOP(NOP_INSTR)
    ) u_ifid (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .clear    (clr),
        .ld_pc    (ld_pc),
        .ld_instr (ld_instr),
        .valid    (ifid_valid),
        .pc       (ifid_pc),
        .pc4      (ifid_pc4),
        .instr    (ifid_instr)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: transaction-level model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        flush;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic [31:0] tgt;

    if_stage #(
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .flush       (flush),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4),
        .ifid_instr  (ifid_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Transaction model: outstanding fetch (live or squashed), skid
    // entry, IF/ID contents, and the PC register it drives.
    logic        m_busy  = 1'b0;
    logic        m_dead  = 1'b0;
    logic [31:0] m_opc   = 32'h0;
    logic        m_bv    = 1'b0;
    logic [31:0] m_bpc   = 32'h0;
    logic [31:0] m_bi    = 32'h0;
    logic        m_v     = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_pc4   = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] nxt_pc  = 32'h0;

    function automatic logic e_req();
        return rst && !m_busy && !m_bv && !flush;
    endfunction

    function automatic logic e_stall();
        return !(rst && (flush || (e_req() && imem_gnt)));
    endfunction

    always @(posedge clk or negedge rst) begin
        logic fire, resp;
        if (!rst) begin
            m_busy = 0; m_dead = 0; m_opc = 0;
            m_bv = 0; m_bpc = 0; m_bi = 0;
            m_v = 0; m_pc = 0; m_pc4 = 0; m_instr = 0;
            nxt_pc = 0;
        end else begin
            fire = e_req() && imem_gnt;
            resp = m_busy && imem_rvalid;
            nxt_pc = flush ? tgt : (fire ? pc + 32'd4 : pc);
            if (flush) begin
                m_v = 0; m_instr = 0; m_bv = 0;
            end else if (resp && !m_dead) begin
                if (!id_stall || !m_v) begin
                    m_v = 1; m_pc = m_opc;
                    m_pc4 = m_opc + 32'd4; m_instr = mem(m_opc);
                end else begin
                    m_bv = 1; m_bpc = m_opc; m_bi = mem(m_opc);
                end
            end else if (m_bv && !id_stall) begin
                m_v = 1; m_pc = m_bpc;
                m_pc4 = m_bpc + 32'd4; m_instr = m_bi; m_bv = 0;
            end else if (!id_stall) begin
                m_v = 0; m_instr = 0;
            end
            if (resp) begin
                m_busy = 0; m_dead = 0;
            end else if (flush && m_busy) begin
                m_dead = 1;
            end
            if (fire) begin
                m_busy = 1; m_dead = 0; m_opc = pc;
            end
        end
    end

    always @(negedge clk) begin
        check("imem_req", {31'b0, imem_req}, {31'b0, e_req()});
        check("imem_addr", imem_addr, pc);
        check("pc_stall", {31'b0, pc_stall}, {31'b0, e_stall()});
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
        check("ifid_pc", ifid_pc, m_pc);
        check("ifid_pc4", ifid_pc4, m_pc4);
        check("ifid_instr", ifid_instr, m_instr);
    end

    task automatic cyc(input logic g, input logic rv,
                       input logic st, input logic fl);
        @(posedge clk);
        #1;
        pc          = nxt_pc;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rv ? mem(m_opc) : 32'hDEAD_BEEF;
        id_stall    = st;
        flush       = fl;
        #1;
    endtask

    initial begin
        rst = 0; pc = 0; imem_gnt = 0; imem_rvalid = 0;
        imem_rdata = 0; id_stall = 0; flush = 0; tgt = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_stall", {31'b0, pc_stall}, 32'd1);
        check("rst_instr", ifid_instr, 32'h0);
        rst = 1;
        #1;

        // back-to-back fetches from 0
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            check("seq_wait_stall", {31'b0, pc_stall}, 32'd1);
            cyc(1, 0, 0, 0);
            check("seq_pc", ifid_pc, 32'(4 * i));
            check("seq_pc4", ifid_pc4, 32'(4 * i + 4));
            check("seq_valid", {31'b0, ifid_valid}, 32'd1);
            check("seq_gnt_stall", {31'b0, pc_stall}, 32'd0);
        end

        // grant withheld at 0x10
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            check("nogt_req", {31'b0, imem_req}, 32'd1);
            check("nogt_addr", imem_addr, 32'h10);
            check("nogt_stall", {31'b0, pc_stall}, 32'd1);
        end
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int j = 0; j < 4; j++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 1, 0, 0);
        end

        // back-pressure into the skid buffer
        cyc(1, 0, 1, 0);
        check("bp_hold_pc", ifid_pc, 32'h20);
        cyc(0, 1, 1, 0);
        cyc(1, 0, 1, 0);
        check("bp_no_req", {31'b0, imem_req}, 32'd0);
        check("bp_hold2", ifid_pc, 32'h20);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("bp_drain_pc", ifid_pc, 32'h24);
        check("bp_resume", imem_addr, 32'h28);
        check("bp_resume_req", {31'b0, imem_req}, 32'd1);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);

        // flush while waiting for 0x30
        cyc(1, 0, 0, 0);
        tgt = 32'h100;
        cyc(0, 0, 0, 1);
        check("fl_stall", {31'b0, pc_stall}, 32'd0);
        cyc(0, 1, 0, 0);
        check("fl_drop_req", {31'b0, imem_req}, 32'd0);
        cyc(1, 0, 0, 0);
        check("fl_valid", {31'b0, ifid_valid}, 32'd0);
        check("fl_instr", ifid_instr, 32'h0);
        check("fl_target", imem_addr, 32'h100);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 0);
        check("fl_first", ifid_pc, 32'h100);
        cyc(0, 1, 1, 0);

        // flush + id_stall with full buffer
        tgt = 32'hFFFF_FFFC;
        cyc(0, 0, 1, 1);
        cyc(1, 0, 0, 0);
        check("flbuf_valid", {31'b0, ifid_valid}, 32'd0);
        check("flbuf_req", {31'b0, imem_req}, 32'd1);
        check("flbuf_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 0);
        check("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", ifid_pc4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        // asynchronous reset while waiting
        @(posedge clk);
        #3;
        imem_gnt = 0; id_stall = 0;
        rst = 0;
        #1;
        check("arst_valid", {31'b0, ifid_valid}, 32'd0);
        check("arst_pc", ifid_pc, 32'h0);
        check("arst_pc4", ifid_pc4, 32'h0);
        check("arst_instr", ifid_instr, 32'h0);
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_stall", {31'b0, pc_stall}, 32'd1);
        cyc(0, 0, 0, 0);
        rst = 1;
        #1;
        cyc(0, 1, 0, 0);
        check("late_req", {31'b0, imem_req}, 32'd1);
        cyc(0, 0, 0, 0);
        check("late_valid", {31'b0, ifid_valid}, 32'd0);
        @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
